// File: rtl/pwm_pkg.sv
// Shared constants and elaboration checks for the multi-channel PWM core.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  localparam int unsigned DEFAULT_NUM_CH = 4;
  localparam int unsigned DEFAULT_CNT_W  = 32;
  localparam int unsigned MAX_NUM_CH     = 16;

  typedef enum logic {
    DirUp   = 1'b0,
    DirDown = 1'b1
  } dir_e;

  function automatic bit num_ch_ok(input int unsigned n);
    return (n >= 1) && (n <= MAX_NUM_CH);
  endfunction

  function automatic bit cnt_w_ok(input int unsigned w);
    return (w >= 8) && (w <= 32);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM counter: edge-aligned sawtooth or center-aligned up/down,
// with terminal-cycle detect and a registered period_end pulse.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic             mode,
  output logic [CNT_W-1:0] cnt,
  output logic             terminal,
  output logic             period_end
);

  localparam logic [CNT_W-1:0] One = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             dir_q, dir_d;
  logic             period_end_q;

  // Disabled or P=0 falls through to the defaults: counter 0, counting up.
  always_comb begin
    cnt_d = '0;
    dir_d = DirUp;
    if (en && (period != '0)) begin
      if (mode == MODE_EDGE) begin
        if (cnt_q < period) cnt_d = cnt_q + One;
      end else if (dir_q == DirUp) begin
        if (cnt_q < period) begin
          cnt_d = cnt_q + One;
        end else begin
          cnt_d = period - One;
          dir_d = (period != One) ? DirDown : DirUp;
        end
      end else if (cnt_q > One) begin
        cnt_d = cnt_q - One;
        dir_d = DirDown;
      end
    end
  end

  assign terminal = en && (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      dir_q        <= DirUp;
      period_end_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      period_end_q <= terminal;
    end
  end

  assign cnt        = cnt_q;
  assign period_end = period_end_q;

endmodule

// File: rtl/pwm_multi_core.sv
// Multi-channel PWM: shadow/active register sets with boundary transfer,
// one shared timebase and per-channel compare/polarity output flops.
module pwm_multi_core
  import pwm_pkg::*;
#(
  parameter int unsigned NUM_CH = DEFAULT_NUM_CH,
  parameter int unsigned CNT_W  = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [CNT_W-1:0]        period,
  input  logic [NUM_CH*CNT_W-1:0] pulse_width,
  input  logic                    mode,
  input  logic [NUM_CH-1:0]       polarity,
  input  logic                    load,
  output logic                    load_done,
  output logic                    period_end,
  output logic [NUM_CH-1:0]       pwm
);

  if (!num_ch_ok(NUM_CH) || !cnt_w_ok(CNT_W)) begin : gen_param_check
    $error("pwm_multi_core: NUM_CH must be 1..16 and CNT_W 8..32");
  end

  logic [CNT_W-1:0]        sh_period_q, act_period_q;
  logic [NUM_CH*CNT_W-1:0] sh_width_q, act_width_q;
  logic                    sh_mode_q, act_mode_q;
  logic [NUM_CH-1:0]       sh_pol_q, act_pol_q;
  logic                    pending_q, load_done_q;
  logic [CNT_W-1:0]        cnt;
  logic                    terminal;
  logic                    transfer;

  pwm_timebase #(
    .CNT_W (CNT_W)
  ) u_timebase (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .period     (act_period_q),
    .mode       (act_mode_q),
    .cnt        (cnt),
    .terminal   (terminal),
    .period_end (period_end)
  );

  // While disabled the counter already sits at 0, so any edge is a safe boundary.
  assign transfer = (terminal || !en) && (pending_q || load);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_period_q  <= '0;
      sh_width_q   <= '0;
      sh_mode_q    <= MODE_EDGE;
      sh_pol_q     <= '0;
      act_period_q <= '0;
      act_width_q  <= '0;
      act_mode_q   <= MODE_EDGE;
      act_pol_q    <= '0;
      pending_q    <= 1'b0;
      load_done_q  <= 1'b0;
    end else begin
      if (load) begin
        sh_period_q <= period;
        sh_width_q  <= pulse_width;
        sh_mode_q   <= mode;
        sh_pol_q    <= polarity;
      end
      if (transfer) begin
        // A load coinciding with the boundary bypasses the shadow set.
        act_period_q <= load ? period      : sh_period_q;
        act_width_q  <= load ? pulse_width : sh_width_q;
        act_mode_q   <= load ? mode        : sh_mode_q;
        act_pol_q    <= load ? polarity    : sh_pol_q;
        pending_q    <= 1'b0;
      end else if (load) begin
        pending_q <= 1'b1;
      end
      load_done_q <= transfer;
    end
  end

  assign load_done = load_done_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : gen_ch
    logic raw;
    logic pwm_q;

    assign raw = cnt < act_width_q[i*CNT_W +: CNT_W];

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        pwm_q <= 1'b0;
      end else begin
        pwm_q <= en ? (raw ^ act_pol_q[i]) : act_pol_q[i];
      end
    end

    assign pwm[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi_core.sv
// Scoreboard bench for pwm_multi_core: the driver queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_pwm_multi_core;

  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [CW-1:0]     period;
  logic [NCH*CW-1:0] pulse_width;
  logic              mode;
  logic [NCH-1:0]    polarity;
  logic              load;
  logic              load_done;
  logic              period_end;
  logic [NCH-1:0]    pwm;

  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          phase = 0;

  typedef struct {
    int unsigned cyc;
    int          phase;
    logic [1:0]  pwm;
    logic [1:0]  pmask;
    logic        pe;
    logic        ld;
  } exp_t;

  exp_t q[$];

  pwm_multi_core #(
    .NUM_CH (NCH),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .period      (period),
    .pulse_width (pulse_width),
    .mode        (mode),
    .polarity    (polarity),
    .load        (load),
    .load_done   (load_done),
    .period_end  (period_end),
    .pwm         (pwm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string phase_name(input int p);
    case (p)
      0: return "reset";
      1: return "reload";
      2: return "edge_mode";
      3: return "center_mode";
      4: return "shadow_update";
      5: return "idle_polarity";
      6: return "reset_mid";
      7: return "post_reset";
      8: return "zero_period";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [NCH*CW-1:0] pw(input int w1, input int w0);
    return {CW'(w1), CW'(w0)};
  endfunction

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Expectation for the outputs seen after the next rising edge.
  task automatic expect_all(input logic [1:0] p, input logic pe, input logic ld);
    exp_t e;
    e.cyc   = cyc + 1;
    e.phase = phase;
    e.pwm   = p;
    e.pmask = 2'b11;
    e.pe    = pe;
    e.ld    = ld;
    q.push_back(e);
  endtask

  task automatic reload(input int p, input int w0, input int w1, input logic m,
                        input logic [1:0] pol, input logic [1:0] old_pol);
    int saved;
    saved       = phase;
    phase       = 1;
    en          = 1'b0;
    load        = 1'b1;
    period      = CW'(p);
    pulse_width = pw(w1, w0);
    mode        = m;
    polarity    = pol;
    expect_all(old_pol, 1'b0, 1'b1);
    adv();
    phase = saved;
    load  = 1'b0;
    en    = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc != cyc) begin
          total++;
          bad++;
          $display("FAIL %s: stale expectation for cycle %0d, now %0d",
                   phase_name(e.phase), e.cyc, cyc);
        end else begin
          for (int i = 0; i < NCH; i++) begin
            if (e.pmask[i]) begin
              total++;
              if (pwm[i] !== e.pwm[i]) begin
                bad++;
                $display("FAIL %s pwm[%0d] cyc=%0d: got %b want %b",
                         phase_name(e.phase), i, cyc, pwm[i], e.pwm[i]);
              end
            end
          end
          total++;
          if (period_end !== e.pe) begin
            bad++;
            $display("FAIL %s period_end cyc=%0d: got %b want %b",
                     phase_name(e.phase), cyc, period_end, e.pe);
          end
          total++;
          if (load_done !== e.ld) begin
            bad++;
            $display("FAIL %s load_done cyc=%0d: got %b want %b",
                     phase_name(e.phase), cyc, load_done, e.ld);
          end
        end
      end
    end
  end

  // Driver
  initial begin
    logic [7:0] c_pwm;
    logic [7:0] c_pe;
    int         wexp;

    rst_n       = 1'b0;
    en          = 1'b0;
    mode        = 1'b0;
    load        = 1'b0;
    period      = '0;
    pulse_width = '0;
    polarity    = '0;
    adv();

    phase = 0;
    expect_all(2'b00, 1'b0, 1'b0);
    adv();
    expect_all(2'b00, 1'b0, 1'b0);
    adv();
    rst_n = 1'b1;

    // Edge mode P=9, W={3,10}: ch0 high 3/10, ch1 always high.
    reload(9, 3, 10, 1'b0, 2'b00, 2'b00);
    phase = 2;
    for (int k = 0; k < 30; k++) begin
      expect_all({1'b1, (k % 10) < 3}, (k % 10) == 9, 1'b0);
      adv();
    end

    // Center mode P=4, W0=2: counter 0,1,2,3,4,3,2,1.
    reload(4, 2, 0, 1'b1, 2'b00, 2'b00);
    phase = 3;
    c_pwm = 8'b1000_0011;
    c_pe  = 8'b1000_0000;
    for (int k = 0; k < 24; k++) begin
      expect_all({1'b0, c_pwm[k % 8]}, c_pe[k % 8], 1'b0);
      adv();
    end

    // Mid-period loads (W=5 then W=7), then a load in the terminal cycle (W=2).
    reload(9, 3, 10, 1'b0, 2'b00, 2'b00);
    phase = 4;
    for (int k = 0; k < 40; k++) begin
      wexp = (k < 10) ? 3 : ((k < 30) ? 7 : 2);
      if (k == 2) begin
        load = 1'b1;
        pulse_width = pw(10, 5);
      end else if (k == 4) begin
        load = 1'b1;
        pulse_width = pw(10, 7);
      end else if (k == 29) begin
        load = 1'b1;
        pulse_width = pw(10, 2);
      end else begin
        load = 1'b0;
        pulse_width = pw(10, 1);
      end
      expect_all({1'b1, (k % 10) < wexp}, (k % 10) == 9, (k == 9) || (k == 29));
      adv();
    end
    load = 1'b0;

    // Polarity idle level with en=0, then reset discards a pending load.
    reload(9, 0, 0, 1'b0, 2'b11, 2'b00);
    en    = 1'b0;
    phase = 5;
    expect_all(2'b11, 1'b0, 1'b0);
    adv();
    expect_all(2'b11, 1'b0, 1'b0);
    adv();
    en   = 1'b1;
    load = 1'b1;
    expect_all(2'b11, 1'b0, 1'b0);
    adv();
    load  = 1'b0;
    en    = 1'b0;
    rst_n = 1'b0;
    phase = 6;
    expect_all(2'b00, 1'b0, 1'b0);
    adv();
    rst_n = 1'b1;
    phase = 7;
    for (int k = 0; k < 3; k++) begin
      expect_all(2'b00, 1'b0, 1'b0);
      adv();
    end

    // P=0: every cycle terminal, a load transfers at the very next edge.
    reload(0, 1, 0, 1'b0, 2'b00, 2'b00);
    phase = 8;
    for (int k = 0; k < 10; k++) begin
      if (k == 5) begin
        load = 1'b1;
        pulse_width = pw(0, 0);
      end else begin
        load = 1'b0;
        pulse_width = pw(0, 1);
      end
      expect_all({1'b0, k <= 5}, 1'b1, k == 5);
      adv();
    end
    load = 1'b0;
    en   = 1'b0;

    adv();
    adv();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi_core.md
# pwm_multi_core

Parametrised multi-channel PWM generator, the successor to the single-channel PWM core in the AXI PWM IP. One shared timebase drives NUM_CH compare channels. The timebase runs edge-aligned (sawtooth) or center-aligned (up/down) counting. Per-channel polarity is programmable, and double-buffered (shadow) registers guarantee glitch-free updates at period boundaries. It sits behind the AXI-Lite register file, which drives the configuration ports and the load strobe.

## Interface
- NUM_CH, 4: number of PWM channels (1..16).
- CNT_W, 32: counter, period and pulse-width width (8..32).
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  1  timebase enable; 0 holds the counter at 0 and outputs idle.
- period  in  CNT_W  terminal count P (shadow input).
- pulse_width  in  NUM_CH*CNT_W  per-channel compare W[i], channel i at bits [i*CNT_W +: CNT_W] (shadow input).
- mode  in  1  0 = edge-aligned, 1 = center-aligned (shadow input).
- polarity  in  NUM_CH  1 inverts channel i (shadow input).
- load  in  1  single-cycle strobe: capture all shadow inputs.
- load_done  out  1  one-cycle pulse: shadow values became active.
- period_end  out  1  one-cycle pulse: first cycle of a new period.
- pwm  out  NUM_CH  registered PWM outputs.

## Operation
- Register sets:
  - Shadow set (P, W[], mode, polarity) captured when load=1; the latest load wins.
  - pending flag set by load, cleared on transfer.
  - Active set drives the timebase and compares.
- Edge mode sequence: 0,1,…,P,0,… (period P+1 cycles).
- Center mode sequence: 0,1,…,P,P-1,…,1,0,… (period 2P cycles). A direction flag flips at P (to down) and at 1 (to up). P=1 gives 0,1,0,1.
- P=0 (either mode): the counter stays 0 and every cycle is a terminal cycle.
- Terminal cycle: the cycle whose next counter value is 0 while en=1.
- Transfer: at the edge ending a terminal cycle, if pending or load=1, active <= shadow. If load=1 in that same cycle, the load-cycle input values are bypassed directly into active. The counter restarts at 0, direction up.
- en=0:
  - Counter at 0, direction up.
  - A pending or current load transfers at the next edge.
  - pwm[i] = active polarity[i], the inactive level.
- Compare: raw[i] = (counter < W[i]), unsigned. W[i]=0 gives constant inactive; W[i] > P gives constant active.
- Output: pwm[i] <= raw[i] ^ polarity[i] when en=1 and rst_n=1.
- Reset (rst_n=0 at an edge) sets all of the following to 0:
  - shadow and active sets, pending, counter, direction;
  - pwm, load_done, period_end.
- Reset mid-period aborts immediately, and pending loads are discarded.
- Mode change is applied only at a transfer, never mid-period.

## Timing
- pwm latency: 1 cycle from the counter value, so pwm in cycle n+1 reflects the counter in cycle n.
- First enabled cycle has counter=0, so pwm becomes active from the second enabled cycle when W>0.
- load_done: high for exactly one cycle, the cycle after the transfer edge (counter=0 cycle). A load whose transfer completes without an intervening load gives exactly one pulse.
- period_end: high whenever en=1 and the counter is 0 following a terminal cycle. It is continuously high when P=0 and en=1. It is low on the first enabled cycle after en rises.
- Max load-to-active delay: one full period plus one cycle.

## Structure
- Package pwm_pkg holds:
  - MODE_EDGE=1'b0 and MODE_CENTER=1'b1 constants;
  - default CNT_W and NUM_CH localparams;
  - the NUM_CH limit check.
- Sub-module pwm_timebase holds the counter, direction flag, terminal detect and period_end. Its inputs are active P, mode and en.
- The top level contains the shadow/active registers, the transfer logic, and a generate loop of per-channel compare/polarity flops.

## Test plan
- Edge mode, NUM_CH=2, P=9, W={3,10}, load, then en=1. Required: ch0 is high 3 of every 10 cycles; ch1 is constant high; period_end fires every 10 cycles.
- Center mode, P=4, W=2. Required: counter 0,1,2,3,4,3,2,1 repeating; pwm high 3 of every 8 cycles, centred on counter=0; period_end every 8 cycles.
- Running P=9; load W=5 mid-period, then load W=7 two cycles later. Required:
  - old W holds until the boundary;
  - W=7 applies at the next period start;
  - a single load_done pulse coincides with period_end.
- Load asserted exactly in the terminal cycle (counter=P). Required: new values active in the immediately following period; load_done on that counter=0 cycle.
- Polarity=1 with W=0 and en=0. Required: pwm=1 (idle level). After rst_n=0 for one edge: pwm=0, load_done=0, pending cleared.
- P=0, en=1. Required: counter stuck at 0; period_end constantly high; a load transfers at the very next edge.
